// File: rtl/imm_extend_unit.sv
// RV32I immediate generator: combinational sign/zero-extended immediate plus an
// optional registered copy with valid and illegal flags for pipelined consumers.
module imm_extend_unit #(
  parameter int XLEN       = 32,
  parameter bit REG_OUT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      imm_src,
  input  logic [31:0]     instruction,
  input  logic            in_valid,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [XLEN-1:0] imm_q,
  output logic            imm_vld_q,
  output logic            illegal_q
);

  logic s;
  assign s = instruction[31];

  // Format decode; reserved encoding (and anything unknown) yields zero + illegal.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      3'd0: imm = {{20{s}}, instruction[31:20]};
      3'd1: imm = {{20{s}}, instruction[31:25], instruction[11:7]};
      3'd2: imm = {{19{s}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      3'd3: imm = {{11{s}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      3'd4: imm = {instruction[31:12], 12'h000};
      3'd5: imm = {27'b0, instruction[19:15]};
      3'd6: imm = {27'b0, instruction[24:20]};
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  generate
    if (REG_OUT_EN) begin : g_reg
      // imm_q only captures qualified instructions; the flags track every cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          imm_q     <= '0;
          imm_vld_q <= 1'b0;
          illegal_q <= 1'b0;
        end else begin
          imm_vld_q <= in_valid;
          illegal_q <= illegal & in_valid;
          if (in_valid) begin
            imm_q <= imm;
          end
        end
      end
    end else begin : g_noreg
      assign imm_q     = '0;
      assign imm_vld_q = 1'b0;
      assign illegal_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed format vectors, random
// vectors against a field-level model, registered path and async reset.
module tb_imm_extend_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  imm_src;
  logic [31:0] instruction;
  logic        in_valid;
  logic [31:0] imm;
  logic        illegal;
  logic [31:0] imm_q;
  logic        imm_vld_q;
  logic        illegal_q;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        ill_q[$];
  logic [31:0] reg_q[$];
  logic        vld_q[$];
  logic        rill_q[$];
  logic [31:0] held;

  imm_extend_unit #(.XLEN(32), .REG_OUT_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imm_src     (imm_src),
    .instruction (instruction),
    .in_valid    (in_valid),
    .imm         (imm),
    .illegal     (illegal),
    .imm_q       (imm_q),
    .imm_vld_q   (imm_vld_q),
    .illegal_q   (illegal_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from arithmetic shifts of reassembled fields.
  function automatic logic [31:0] ref_imm(input logic [2:0] src, input logic [31:0] ins);
    logic signed [31:0] t;
    t = '0;
    case (src)
      3'd0: begin t = ins; t = t >>> 20; end
      3'd1: begin t = {ins[31:25], ins[11:7], 20'b0}; t = t >>> 20; end
      3'd2: begin t = {ins[31], ins[7], ins[30:25], ins[11:8], 20'b0}; t = t >>> 19; end
      3'd3: begin t = {ins[31], ins[19:12], ins[20], ins[30:21], 12'b0}; t = t >>> 11; end
      3'd4: t = ins & 32'hFFFF_F000;
      3'd5: t = (ins >> 15) & 32'h1F;
      3'd6: t = (ins >> 20) & 32'h1F;
      default: t = '0;
    endcase
    return t;
  endfunction

  // driver tasks
  task automatic drive_comb(input logic [2:0] src, input logic [31:0] ins, input logic [31:0] e);
    imm_src     = src;
    instruction = ins;
    exp_q.push_back(e);
    ill_q.push_back(src == 3'd7);
  endtask

  task automatic drive_reg(input logic v, input logic [2:0] src, input logic [31:0] ins);
    in_valid    = v;
    imm_src     = src;
    instruction = ins;
    if (v) held = ref_imm(src, ins);
    reg_q.push_back(held);
    vld_q.push_back(v);
    rill_q.push_back(v && (src == 3'd7));
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    imm_src     = 3'd0;
    instruction = 32'hFFF0_0000;
    held        = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (imm_q !== 32'h0 || imm_vld_q !== 1'b0 || illegal_q !== 1'b0) begin
      n_err++;
      $display("FAIL reset: imm_q=%h vld=%b ill=%b, want 0 0 0", imm_q, imm_vld_q, illegal_q);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_i_s_type();
    logic [2:0]  src_t [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [31:0] ins_t [4] = '{32'hFFF0_0000, 32'h7FF0_0000, 32'h0000_0280, 32'hFE00_0F80};
    logic [31:0] exp_t [4] = '{32'hFFFF_FFFF, 32'h0000_07FF, 32'h0000_0005, 32'hFFFF_FFFF};
    logic [31:0] e;
    logic        ei;
    for (int i = 0; i < 4; i++) begin
      drive_comb(src_t[i], ins_t[i], exp_t[i]);
      #1;
      e  = exp_q.pop_front();
      ei = ill_q.pop_front();
      n_vec++;
      if (imm !== e || illegal !== ei) begin
        n_err++;
        $display("FAIL i_s_type[%0d]: imm=%h illegal=%b, want %h %b", i, imm, illegal, e, ei);
      end
    end
  endtask

  task automatic test_b_j_u_type();
    logic [2:0]  src_t [7] = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd3, 3'd3, 3'd3};
    logic [31:0] ins_t [7] = '{32'h8000_0000, 32'h0000_0080, 32'h7E00_0F80,
                               32'hFFFF_FFFF, 32'h8000_0000, 32'h0010_0000, 32'h7FFF_F000};
    logic [31:0] exp_t [7] = '{32'hFFFF_F000, 32'h0000_0800, 32'h0000_0FFE,
                               32'hFFFF_F000, 32'hFFF0_0000, 32'h0000_0800, 32'h000F_FFFE};
    logic [31:0] e;
    logic        ei;
    for (int i = 0; i < 7; i++) begin
      drive_comb(src_t[i], ins_t[i], exp_t[i]);
      #1;
      e  = exp_q.pop_front();
      ei = ill_q.pop_front();
      n_vec++;
      if (imm !== e || illegal !== ei) begin
        n_err++;
        $display("FAIL b_j_u_type[%0d]: imm=%h illegal=%b, want %h %b", i, imm, illegal, e, ei);
      end
    end
  endtask

  task automatic test_zext_reserved();
    logic [2:0]  src_t [4] = '{3'd5, 3'd6, 3'd7, 3'd7};
    logic [31:0] ins_t [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] exp_t [4] = '{32'h0000_001F, 32'h0000_001F, 32'h0, 32'h0};
    logic [31:0] e;
    logic        ei;
    for (int i = 0; i < 4; i++) begin
      drive_comb(src_t[i], ins_t[i], exp_t[i]);
      #1;
      e  = exp_q.pop_front();
      ei = ill_q.pop_front();
      n_vec++;
      if (imm !== e || illegal !== ei) begin
        n_err++;
        $display("FAIL zext_reserved[%0d]: imm=%h illegal=%b, want %h %b", i, imm, illegal, e, ei);
      end
    end
  endtask

  task automatic test_random_comb();
    logic [2:0]  src;
    logic [31:0] ins;
    logic [31:0] e;
    logic        ei;
    for (int i = 0; i < 60; i++) begin
      src = 3'($urandom_range(0, 7));
      ins = $urandom;
      drive_comb(src, ins, ref_imm(src, ins));
      #1;
      e  = exp_q.pop_front();
      ei = ill_q.pop_front();
      n_vec++;
      if (imm !== e || illegal !== ei) begin
        n_err++;
        $display("FAIL random_comb[%0d] src=%0d ins=%h: imm=%h illegal=%b, want %h %b",
                 i, src, ins, imm, illegal, e, ei);
      end
    end
  endtask

  task automatic test_registered();
    logic        v_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  src_t [4] = '{3'd0, 3'd6, 3'd7, 3'd7};
    logic [31:0] ins_t [4] = '{32'hFFF0_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] e;
    logic        ev, ei;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_reg(v_t[i], src_t[i], ins_t[i]);
      @(posedge clk);
      #1;
      e  = reg_q.pop_front();
      ev = vld_q.pop_front();
      ei = rill_q.pop_front();
      n_vec++;
      if (imm_q !== e || imm_vld_q !== ev || illegal_q !== ei) begin
        n_err++;
        $display("FAIL registered[%0d]: imm_q=%h vld=%b ill=%b, want %h %b %b",
                 i, imm_q, imm_vld_q, illegal_q, e, ev, ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic        ev, ei;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_reg(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      @(posedge clk);
      #1;
      e  = reg_q.pop_front();
      ev = vld_q.pop_front();
      ei = rill_q.pop_front();
      n_vec++;
      if (imm_q !== e || imm_vld_q !== ev || illegal_q !== ei) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: imm_q=%h vld=%b ill=%b, want %h %b %b",
                 i, imm_q, imm_vld_q, illegal_q, e, ev, ei);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    logic        ev, ei;
    @(negedge clk);
    drive_reg(1'b1, 3'd0, 32'hFFF0_0000);
    @(posedge clk);
    #1;
    e  = reg_q.pop_front();
    ev = vld_q.pop_front();
    ei = rill_q.pop_front();
    n_vec++;
    if (imm_q !== e || imm_vld_q !== ev || illegal_q !== ei) begin
      n_err++;
      $display("FAIL async_load: imm_q=%h vld=%b ill=%b, want %h %b %b",
               imm_q, imm_vld_q, illegal_q, e, ev, ei);
    end
    // assert reset between edges, outputs must clear without a clock
    #1;
    rst_n = 1'b0;
    held  = '0;
    #1;
    n_vec++;
    if (imm_q !== 32'h0 || imm_vld_q !== 1'b0 || illegal_q !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear: imm_q=%h vld=%b ill=%b, want 0 0 0", imm_q, imm_vld_q, illegal_q);
    end
    // combinational path keeps working while held in reset
    @(negedge clk);
    in_valid    = 1'b1;
    imm_src     = 3'd7;
    instruction = 32'h0000_0000;
    #1;
    n_vec++;
    if (imm !== 32'h0 || illegal !== 1'b1) begin
      n_err++;
      $display("FAIL comb_in_reset: imm=%h illegal=%b, want 0 1", imm, illegal);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (imm_q !== 32'h0 || imm_vld_q !== 1'b0 || illegal_q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: imm_q=%h vld=%b ill=%b, want 0 0 0", imm_q, imm_vld_q, illegal_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_reg(1'b1, 3'd7, 32'h0000_0000);
    @(posedge clk);
    #1;
    e  = reg_q.pop_front();
    ev = vld_q.pop_front();
    ei = rill_q.pop_front();
    n_vec++;
    if (imm_q !== e || imm_vld_q !== ev || illegal_q !== ei) begin
      n_err++;
      $display("FAIL after_release: imm_q=%h vld=%b ill=%b, want %h %b %b",
               imm_q, imm_vld_q, illegal_q, e, ev, ei);
    end
  endtask

  initial begin
    test_reset();
    test_i_s_type();
    test_b_j_u_type();
    test_zext_reserved();
    test_random_comb();
    test_registered();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
